// File: rtl/sc_ir_fetch_register_if.sv
// -----------------------------------------------------------------------------
// sc_ir_fetch_register_if
// Memory-to-instruction-register handshake bundle.
//   SC_IR_MEM_DATA   instruction word from memory
//   SC_IR_MEM_VALID  memory drives a valid word this cycle
//   SC_IR_MEM_READY  instruction register accepts the word this cycle
// A beat transfers on a rising clock edge where VALID and READY are both 1.
// Modports:
//   master - memory side (drives data/valid, observes ready)
//   slave  - instruction register side (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface sc_ir_fetch_register_if #(
    parameter int DATAWIDTH_BUS = 32
);
    logic [DATAWIDTH_BUS-1:0] SC_IR_MEM_DATA;
    logic                     SC_IR_MEM_VALID;
    logic                     SC_IR_MEM_READY;

    modport master (
        output SC_IR_MEM_DATA,
        output SC_IR_MEM_VALID,
        input  SC_IR_MEM_READY
    );

    modport slave (
        input  SC_IR_MEM_DATA,
        input  SC_IR_MEM_VALID,
        output SC_IR_MEM_READY
    );
endinterface

// File: rtl/sc_ir_fetch_register.sv
// -----------------------------------------------------------------------------
// sc_ir_fetch_register
// Instruction register stage feeding the CC register-select muxes. Fetches a
// 32-bit SPARC-format instruction from memory over a valid/ready handshake,
// holds it and exposes its decoded fields. A watchdog raises a sticky timeout
// flag if memory does not answer a fetch within TIMEOUT_CYCLES cycles.
//
// Ports:
//   SC_IR_CLOCK_50      in   system clock, rising edge
//   SC_IR_RESET_InLow   in   asynchronous reset, active low
//   SC_IR_LOAD_InHigh   in   request: fetch next instruction
//   SC_IR_FLUSH_InHigh  in   discard held/pending instruction
//   mem_if (slave)           MEM_DATA / MEM_VALID in, MEM_READY out
//   SC_IR_VALID         out  held instruction valid
//   SC_IR_TIMEOUT       out  sticky fetch-timeout error flag
//   SC_IR_RD/RS1/RS2    out  register fields IR[29:25] / IR[18:14] / IR[4:0]
//   SC_IR_OP/OP2/OP3    out  IR[31:30] / IR[24:22] / IR[24:19]
//   SC_IR_BIT13         out  IR[13], immediate select
//   SC_IR_SIMM13        out  IR[12:0] sign-extended
//   SC_IR_PREV          out  previous IR (only with SC_IR_SHADOW_EN)
//
// Optional feature macro: SC_IR_SHADOW_EN
//   When defined, a shadow register keeps the instruction that was replaced by
//   the most recent handshake (for trap re-execution). FLUSH leaves it intact.
// -----------------------------------------------------------------------------
module sc_ir_fetch_register #(
    parameter int DATAWIDTH_BUS      = 32,
    parameter int DATAWIDTH_IR_FIELD = 5,
    parameter int TIMEOUT_CYCLES     = 16,
    parameter int DATAWIDTH_TIMEOUT  = 5
) (
    input  logic                          SC_IR_CLOCK_50,
    input  logic                          SC_IR_RESET_InLow,
    input  logic                          SC_IR_LOAD_InHigh,
    input  logic                          SC_IR_FLUSH_InHigh,
    sc_ir_fetch_register_if.slave         mem_if,
    output logic                          SC_IR_VALID,
    output logic                          SC_IR_TIMEOUT,
    output logic [DATAWIDTH_IR_FIELD-1:0] SC_IR_RD,
    output logic [DATAWIDTH_IR_FIELD-1:0] SC_IR_RS1,
    output logic [DATAWIDTH_IR_FIELD-1:0] SC_IR_RS2,
    output logic [1:0]                    SC_IR_OP,
    output logic [2:0]                    SC_IR_OP2,
    output logic [5:0]                    SC_IR_OP3,
    output logic                          SC_IR_BIT13,
`ifdef SC_IR_SHADOW_EN
    output logic [DATAWIDTH_BUS-1:0]      SC_IR_PREV,
`endif
    output logic [DATAWIDTH_BUS-1:0]      SC_IR_SIMM13
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Last counter value before the watchdog fires.
    localparam logic [DATAWIDTH_TIMEOUT-1:0] COUNT_LAST =
        DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

    state_t                         state_r;
    state_t                         state_next_s;
    logic [DATAWIDTH_TIMEOUT-1:0]   count_r;
    logic [DATAWIDTH_TIMEOUT-1:0]   count_next_s;
    logic [DATAWIDTH_BUS-1:0]       ir_r;
    logic [DATAWIDTH_BUS-1:0]       ir_next_s;
    logic                           timeout_r;
    logic                           timeout_next_s;
    logic                           capture_s;
    logic                           mem_ready_r;
    logic                           mem_ready_next_s;
    logic                           valid_r;
    logic                           valid_next_s;
`ifdef SC_IR_SHADOW_EN
    logic [DATAWIDTH_BUS-1:0]       prev_r;
`endif

    // State register.
    always_ff @(posedge SC_IR_CLOCK_50 or negedge SC_IR_RESET_InLow) begin
        if (!SC_IR_RESET_InLow) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath-next logic; FLUSH overrides handshake, handshake overrides LOAD.
    always_comb begin
        state_next_s   = state_r;
        count_next_s   = count_r;
        ir_next_s      = ir_r;
        timeout_next_s = timeout_r;
        capture_s      = 1'b0;
        if (SC_IR_FLUSH_InHigh) begin
            state_next_s = ST_IDLE;
            count_next_s = {DATAWIDTH_TIMEOUT{1'b0}};
            ir_next_s    = {DATAWIDTH_BUS{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (SC_IR_LOAD_InHigh) begin
                        state_next_s = ST_FETCH;
                        count_next_s = {DATAWIDTH_TIMEOUT{1'b0}};
                    end else begin
                        state_next_s = state_r;
                    end
                end
                ST_FETCH: begin
                    // READY is high throughout FETCH, so MEM_VALID alone completes the beat.
                    // LOAD is deliberately ignored here: no restart of the watchdog.
                    if (mem_if.SC_IR_MEM_VALID) begin
                        state_next_s   = ST_HOLD;
                        ir_next_s      = mem_if.SC_IR_MEM_DATA;
                        timeout_next_s = 1'b0;
                        capture_s      = 1'b1;
                    end else if (count_r == COUNT_LAST) begin
                        state_next_s   = ST_IDLE;
                        count_next_s   = {DATAWIDTH_TIMEOUT{1'b0}};
                        timeout_next_s = 1'b1;
                    end else begin
                        count_next_s = count_r + {{(DATAWIDTH_TIMEOUT-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    count_next_s = {DATAWIDTH_TIMEOUT{1'b0}};
                end
            endcase
        end
    end

    // Output decode from the next state so the registered flags line up with the state.
    always_comb begin
        mem_ready_next_s = 1'b0;
        valid_next_s     = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                mem_ready_next_s = 1'b0;
                valid_next_s     = 1'b0;
            end
            ST_FETCH: begin
                mem_ready_next_s = 1'b1;
                valid_next_s     = 1'b0;
            end
            ST_HOLD: begin
                mem_ready_next_s = 1'b0;
                valid_next_s     = 1'b1;
            end
            default: begin
                mem_ready_next_s = 1'b0;
                valid_next_s     = 1'b0;
            end
        endcase
    end

    // Registered handshake/status outputs.
    always_ff @(posedge SC_IR_CLOCK_50 or negedge SC_IR_RESET_InLow) begin
        if (!SC_IR_RESET_InLow) begin
            mem_ready_r <= 1'b0;
            valid_r     <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            mem_ready_r <= mem_ready_next_s;
            valid_r     <= valid_next_s;
            timeout_r   <= timeout_next_s;
        end
    end

    // Instruction register and watchdog counter.
    always_ff @(posedge SC_IR_CLOCK_50 or negedge SC_IR_RESET_InLow) begin
        if (!SC_IR_RESET_InLow) begin
            ir_r    <= {DATAWIDTH_BUS{1'b0}};
            count_r <= {DATAWIDTH_TIMEOUT{1'b0}};
        end else begin
            ir_r    <= ir_next_s;
            count_r <= count_next_s;
        end
    end

`ifdef SC_IR_SHADOW_EN
    // Shadow copy of the instruction being replaced; FLUSH does not touch it.
    always_ff @(posedge SC_IR_CLOCK_50 or negedge SC_IR_RESET_InLow) begin
        if (!SC_IR_RESET_InLow) begin
            prev_r <= {DATAWIDTH_BUS{1'b0}};
        end else if (capture_s) begin
            prev_r <= ir_r;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign SC_IR_PREV = prev_r;
`endif

    assign mem_if.SC_IR_MEM_READY = mem_ready_r;
    assign SC_IR_VALID            = valid_r;
    assign SC_IR_TIMEOUT          = timeout_r;

    // Field slices are ungated; consumers qualify them with SC_IR_VALID.
    assign SC_IR_OP     = ir_r[31:30];
    assign SC_IR_RD     = ir_r[29:25];
    assign SC_IR_OP2    = ir_r[24:22];
    assign SC_IR_OP3    = ir_r[24:19];
    assign SC_IR_RS1    = ir_r[18:14];
    assign SC_IR_BIT13  = ir_r[13];
    assign SC_IR_RS2    = ir_r[4:0];
    assign SC_IR_SIMM13 = {{(DATAWIDTH_BUS-13){ir_r[12]}}, ir_r[12:0]};

endmodule

// File: tb/tb_sc_ir_fetch_register.sv
// -----------------------------------------------------------------------------
// tb_sc_ir_fetch_register
// Self-checking bench for sc_ir_fetch_register: directed scenarios followed by
// a randomized phase, all compared against a behavioural model of the fetch
// protocol held in this module.
// -----------------------------------------------------------------------------
module tb_sc_ir_fetch_register;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic        flush;
    logic        ir_valid;
    logic        ir_timeout;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic        bit13;
    logic [31:0] simm13;
`ifdef SC_IR_SHADOW_EN
    logic [31:0] prev;
`endif

    int n_assert;
    int n_fail;

    // Behavioural model of the fetch protocol.
    bit          m_fetching;
    bit          m_holding;
    bit          m_timeout;
    int          m_wait;
    logic [31:0] m_ir;
    logic [31:0] m_prev;

    sc_ir_fetch_register_if #(.DATAWIDTH_BUS(32)) mem_bus ();

    sc_ir_fetch_register dut (
        .SC_IR_CLOCK_50     (clk),
        .SC_IR_RESET_InLow  (rst_n),
        .SC_IR_LOAD_InHigh  (load),
        .SC_IR_FLUSH_InHigh (flush),
        .mem_if             (mem_bus.slave),
        .SC_IR_VALID        (ir_valid),
        .SC_IR_TIMEOUT      (ir_timeout),
        .SC_IR_RD           (rd),
        .SC_IR_RS1          (rs1),
        .SC_IR_RS2          (rs2),
        .SC_IR_OP           (op),
        .SC_IR_OP2          (op2),
        .SC_IR_OP3          (op3),
        .SC_IR_BIT13        (bit13),
`ifdef SC_IR_SHADOW_EN
        .SC_IR_PREV         (prev),
`endif
        .SC_IR_SIMM13       (simm13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_fetching = 1'b0;
        m_holding  = 1'b0;
        m_timeout  = 1'b0;
        m_wait     = 0;
        m_ir       = 32'h0;
        m_prev     = 32'h0;
    endtask

    // One clock of protocol behaviour, evaluated on the inputs present at the edge.
    task automatic model_step();
        if (flush) begin
            m_fetching = 1'b0;
            m_holding  = 1'b0;
            m_ir       = 32'h0;
            m_wait     = 0;
        end else if (m_fetching && mem_bus.SC_IR_MEM_VALID) begin
            m_prev     = m_ir;
            m_ir       = mem_bus.SC_IR_MEM_DATA;
            m_fetching = 1'b0;
            m_holding  = 1'b1;
            m_timeout  = 1'b0;
        end else if (m_fetching) begin
            m_wait = m_wait + 1;
            if (m_wait == TIMEOUT) begin
                m_fetching = 1'b0;
                m_timeout  = 1'b1;
            end
        end else if (load) begin
            m_fetching = 1'b1;
            m_holding  = 1'b0;
            m_wait     = 0;
        end
    endtask

    task automatic check_all(input string tag);
        int s;
        s = int'(m_ir & 32'h1FFF);
        if (s >= 4096) s = s - 8192;
        chk({tag, ".ready"},   {31'h0, mem_bus.SC_IR_MEM_READY}, {31'h0, m_fetching});
        chk({tag, ".valid"},   {31'h0, ir_valid},   {31'h0, m_holding});
        chk({tag, ".timeout"}, {31'h0, ir_timeout}, {31'h0, m_timeout});
        chk({tag, ".op"},      {30'h0, op},    (m_ir >> 30) & 32'h3);
        chk({tag, ".rd"},      {27'h0, rd},    (m_ir >> 25) & 32'h1F);
        chk({tag, ".op2"},     {29'h0, op2},   (m_ir >> 22) & 32'h7);
        chk({tag, ".op3"},     {26'h0, op3},   (m_ir >> 19) & 32'h3F);
        chk({tag, ".rs1"},     {27'h0, rs1},   (m_ir >> 14) & 32'h1F);
        chk({tag, ".bit13"},   {31'h0, bit13}, (m_ir >> 13) & 32'h1);
        chk({tag, ".rs2"},     {27'h0, rs2},   m_ir & 32'h1F);
        chk({tag, ".simm13"},  simm13,         32'(s));
`ifdef SC_IR_SHADOW_EN
        chk({tag, ".prev"},    prev,           m_prev);
`endif
    endtask

    // Apply inputs for one clock, advance the model, then sample after the edge.
    task automatic cycle(input string tag, input logic l, input logic f,
                         input logic mv, input logic [31:0] md);
        load                   = l;
        flush                  = f;
        mem_bus.SC_IR_MEM_VALID = mv;
        mem_bus.SC_IR_MEM_DATA  = md;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic fetch_word(input string tag, input logic [31:0] word);
        cycle({tag, ".load"}, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle({tag, ".beat"}, 1'b0, 1'b0, 1'b1, word);
    endtask

    initial begin
        int ready_cnt;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        flush    = 1'b0;
        mem_bus.SC_IR_MEM_VALID = 1'b0;
        mem_bus.SC_IR_MEM_DATA  = 32'h0;
        model_reset();

        // Reset state, then idle.
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle("idle", 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("idle.rd_const",   {27'h0, rd},  32'h0);
        chk("idle.simm_const", simm13,       32'h0);

        // LOAD, one empty cycle, then the beat two cycles after LOAD.
        cycle("f1.load", 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("f1.wait", 1'b0, 1'b0, 1'b0, 32'h1234_5678);
        cycle("f1.beat", 1'b0, 1'b0, 1'b1, 32'h8200_6005);
        chk("f1.valid_const", {31'h0, ir_valid}, 32'h1);
        chk("f1.op_const",    {30'h0, op},       32'h2);
        chk("f1.rd_const",    {27'h0, rd},       32'h1);
        chk("f1.op3_const",   {26'h0, op3},      32'h0);
        chk("f1.rs1_const",   {27'h0, rs1},      32'h1);
        chk("f1.bit13_const", {31'h0, bit13},    32'h1);
        chk("f1.simm_const",  simm13,            32'h0000_0005);
        cycle("f1.hold", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);

        // Negative immediate; LOAD from HOLD.
        fetch_word("f2", 32'h8200_7FFF);
        chk("f2.simm_const", simm13,      32'hFFFF_FFFF);
        chk("f2.rs2_const",  {27'h0, rs2}, 32'h1F);
`ifdef SC_IR_SHADOW_EN
        chk("f2.prev_const", prev, 32'h8200_6005);
        cycle("f2.flush", 1'b0, 1'b1, 1'b0, 32'h0);
        chk("f2.prev_after_flush", prev, 32'h8200_6005);
`endif

        // Watchdog: READY high for exactly TIMEOUT cycles, LOAD ignored while fetching.
        ready_cnt = 0;
        cycle("to.load", 1'b1, 1'b0, 1'b0, 32'h0);
        if (mem_bus.SC_IR_MEM_READY) ready_cnt++;
        for (int i = 0; i < 40 && mem_bus.SC_IR_MEM_READY; i++) begin
            cycle("to.wait", (i == 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, 32'h0);
            if (mem_bus.SC_IR_MEM_READY) ready_cnt++;
        end
        chk("to.ready_cycles", 32'(ready_cnt), 32'(TIMEOUT));
        chk("to.flag_const",   {31'h0, ir_timeout}, 32'h1);
        cycle("to.flush_keeps", 1'b0, 1'b1, 1'b0, 32'h0);
        fetch_word("to.recover", 32'h0123_4567);
        chk("to.cleared_const", {31'h0, ir_timeout}, 32'h0);

        // Handshake on the expiry edge wins.
        cycle("edge.load", 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) cycle("edge.wait", 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("edge.beat", 1'b0, 1'b0, 1'b1, 32'hC0FF_EE11);
        chk("edge.no_timeout", {31'h0, ir_timeout}, 32'h0);

        // FLUSH together with MEM_VALID in FETCH: no capture.
        cycle("fl.load", 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("fl.both", 1'b0, 1'b1, 1'b1, 32'hAAAA_5555);
        chk("fl.simm_const", simm13, 32'h0);

        // Reset asserted mid-FETCH drops READY without a clock edge.
        cycle("rst.load", 1'b1, 1'b0, 1'b0, 32'h0);
        load = 1'b0;
        mem_bus.SC_IR_MEM_VALID = 1'b1;
        mem_bus.SC_IR_MEM_DATA  = 32'h8765_4321;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async_ready", {31'h0, mem_bus.SC_IR_MEM_READY}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        check_all("rst.held");
        rst_n = 1'b1;
        cycle("rst.after", 1'b0, 1'b0, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle("rnd",
                  ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                  $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
